// File: rtl/qqspi_arbiter.sv
// -----------------------------------------------------------------------------
// qqspi_arbiter
//
// Purpose:
//   Shares one qqspi memory controller (PSRAM / SPI-flash, 8Mx32 word space)
//   between two bus requesters. One request at a time is latched and handed
//   to the controller with a valid/ready handshake. The controller's ready is
//   sticky (it stays high until the controller sees valid low), so the
//   arbiter waits for ready to drop before it makes the next grant. Read data
//   is returned to the granted requester together with a one-cycle ready
//   pulse.
//
// Parameters:
//   FIXED_PRIO : 0 = round-robin on simultaneous requests,
//                1 = port 0 always wins simultaneous requests
//   ADDR_W     : word address width (23 for 8Mx32)
//
// Ports:
//   clk, resetn            system clock, asynchronous active-low reset
//   pN_valid               port N request, held by the requester until pN_ready
//   pN_addr/wdata/wstrb    port N request fields (wstrb == 0 means read);
//                          only sampled in the cycle the request is granted
//   pN_ready               port N one-cycle completion pulse
//   pN_rdata               port N read data, valid while pN_ready
//   mem_valid              request to the controller
//   mem_addr/wdata/wstrb   latched request fields towards the controller
//   mem_ready              controller completion (sticky until valid drops)
//   mem_rdata              controller read data, valid while mem_ready
//   grant                  port currently or last served
//   busy                   high whenever a transaction is in progress
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module qqspi_arbiter #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned ADDR_W     = 23
) (
  input  logic              clk,
  input  logic              resetn,
  // port 0
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [3:0]        p0_wstrb,
  output logic              p0_ready,
  output logic [31:0]       p0_rdata,
  // port 1
  input  logic              p1_valid,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [3:0]        p1_wstrb,
  output logic              p1_ready,
  output logic [31:0]       p1_rdata,
  // controller side
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  // status
  output logic              grant,
  output logic              busy
);

  // IDLE    : waiting for a request (and for a quiet controller)
  // ISSUE   : request presented to the controller, waiting for mem_ready
  // RELEASE : completion returned, waiting for the controller to drop ready
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic                mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_wstrb_q, mem_wstrb_d;
  logic                p0_ready_q,  p0_ready_d;
  logic                p1_ready_q,  p1_ready_d;
  logic [31:0]         p0_rdata_q,  p0_rdata_d;
  logic [31:0]         p1_rdata_q,  p1_rdata_d;
  logic                grant_q,     grant_d;
  logic                busy_q,      busy_d;

  // Port that would win if a grant were made this cycle.
  logic                win_s;

  // Arbitration: a lone requester always wins; on a tie either port 0 wins
  // (fixed priority) or the port that was not served last wins. grant resets
  // to 1 so port 0 takes the first round-robin tie.
  always_comb begin
    win_s = 1'b0;
    if (p0_valid && p1_valid) begin
      if (FIXED_PRIO) begin
        win_s = 1'b0;
      end else begin
        win_s = ~grant_q;
      end
    end else if (p1_valid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state and next-output logic of the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    p0_ready_d  = 1'b0;
    p1_ready_d  = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    grant_d     = grant_q;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        // A ready still high here is stale (left over from a previous
        // completion); granting now could let it complete the new request.
        if (!mem_ready && (p0_valid || p1_valid)) begin
          grant_d     = win_s;
          mem_addr_d  = win_s ? p1_addr  : p0_addr;
          mem_wdata_d = win_s ? p1_wdata : p0_wdata;
          mem_wstrb_d = win_s ? p1_wstrb : p0_wstrb;
          mem_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          mem_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        // Completion is delivered even if the requester dropped its valid.
        if (mem_ready) begin
          if (grant_q) begin
            p1_rdata_d = mem_rdata;
            p1_ready_d = 1'b1;
          end else begin
            p0_rdata_d = mem_rdata;
            p0_ready_d = 1'b1;
          end
          mem_valid_d = 1'b0;
          state_d     = ST_RELEASE;
        end else begin
          mem_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end
        busy_d = 1'b1;
      end

      ST_RELEASE: begin
        mem_valid_d = 1'b0;
        if (!mem_ready) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          busy_d  = 1'b1;
          state_d = ST_RELEASE;
        end
      end

      default: begin
        mem_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 32'h0000_0000;
      mem_wstrb_q <= 4'b0000;
      p0_ready_q  <= 1'b0;
      p1_ready_q  <= 1'b0;
      p0_rdata_q  <= 32'h0000_0000;
      p1_rdata_q  <= 32'h0000_0000;
      grant_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      p0_ready_q  <= p0_ready_d;
      p1_ready_q  <= p1_ready_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign p0_ready  = p0_ready_q;
  assign p1_ready  = p1_ready_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_qqspi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qqspi_arbiter
//
// Two arbiters run side by side: instance 0 round-robin, instance 1 fixed
// priority. Each has its own requesters and its own controller model. A
// transaction-level reference model per instance predicts every output each
// cycle; directed sequences add literal expectations for the key scenarios.
// -----------------------------------------------------------------------------
module tb_qqspi_arbiter;

  localparam int AW = 23;
  localparam int NI = 2;

  logic              clk;
  logic              resetn;

  logic              p0_valid  [NI];
  logic [AW-1:0]     p0_addr   [NI];
  logic [31:0]       p0_wdata  [NI];
  logic [3:0]        p0_wstrb  [NI];
  logic              p0_ready  [NI];
  logic [31:0]       p0_rdata  [NI];
  logic              p1_valid  [NI];
  logic [AW-1:0]     p1_addr   [NI];
  logic [31:0]       p1_wdata  [NI];
  logic [3:0]        p1_wstrb  [NI];
  logic              p1_ready  [NI];
  logic [31:0]       p1_rdata  [NI];
  logic              mem_valid [NI];
  logic [AW-1:0]     mem_addr  [NI];
  logic [31:0]       mem_wdata [NI];
  logic [3:0]        mem_wstrb [NI];
  logic              mem_ready [NI];
  logic [31:0]       mem_rdata [NI];
  logic              grant     [NI];
  logic              busy      [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    qqspi_arbiter #(.FIXED_PRIO(k == 1), .ADDR_W(AW)) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .p0_valid  (p0_valid[k]),
      .p0_addr   (p0_addr[k]),
      .p0_wdata  (p0_wdata[k]),
      .p0_wstrb  (p0_wstrb[k]),
      .p0_ready  (p0_ready[k]),
      .p0_rdata  (p0_rdata[k]),
      .p1_valid  (p1_valid[k]),
      .p1_addr   (p1_addr[k]),
      .p1_wdata  (p1_wdata[k]),
      .p1_wstrb  (p1_wstrb[k]),
      .p1_ready  (p1_ready[k]),
      .p1_rdata  (p1_rdata[k]),
      .mem_valid (mem_valid[k]),
      .mem_addr  (mem_addr[k]),
      .mem_wdata (mem_wdata[k]),
      .mem_wstrb (mem_wstrb[k]),
      .mem_ready (mem_ready[k]),
      .mem_rdata (mem_rdata[k]),
      .grant     (grant[k]),
      .busy      (busy[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (transaction level) ----------------
  bit            m_inflight [NI];   // request handed over, completion pending
  bit            m_draining [NI];   // completion given, controller ready still up
  logic          m_grant    [NI];
  logic [AW-1:0] m_addr     [NI];
  logic [31:0]   m_wdata    [NI];
  logic [3:0]    m_wstrb    [NI];
  logic          m_ready    [NI][2];
  logic [31:0]   m_rdata    [NI][2];
  int            n_granted  [NI];
  logic          first_port [NI][8];
  int            pulses     [NI][2];
  int            wait_n     [NI][2];

  // ---------------- stimulus knobs ----------------
  bit auto_on;      // requesters/controllers react automatically after each cycle
  int req_mode;     // 0 random, 1 both ports hold valid, 2 only port 1 holds
  bit rnd_on;       // controller random latency plus stale ready pulses
  int hold_max;     // max extra cycles ready stays up after valid drops
  int ctl_hold [NI];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_inflight[k] = 1'b0;
    m_draining[k] = 1'b0;
    m_grant[k]    = 1'b1;
    m_addr[k]     = '0;
    m_wdata[k]    = 32'h0;
    m_wstrb[k]    = 4'h0;
    for (int p = 0; p < 2; p++) begin
      m_ready[k][p] = 1'b0;
      m_rdata[k][p] = 32'h0;
      wait_n[k][p]  = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step(input int k);
    logic v [2];
    int   w;
    int   g;
    v[0] = p0_valid[k];
    v[1] = p1_valid[k];
    m_ready[k][0] = 1'b0;
    m_ready[k][1] = 1'b0;
    if (!resetn) begin
      model_reset(k);
      return;
    end
    for (int p = 0; p < 2; p++) if (!v[p]) wait_n[k][p] = 0;
    if (m_inflight[k]) begin
      if (mem_ready[k]) begin
        g = m_grant[k] ? 1 : 0;
        m_ready[k][g] = 1'b1;
        m_rdata[k][g] = mem_rdata[k];
        pulses[k][g]++;
        m_inflight[k] = 1'b0;
        m_draining[k] = 1'b1;
      end
    end else if (m_draining[k]) begin
      if (!mem_ready[k]) m_draining[k] = 1'b0;
    end else if (!mem_ready[k] && (v[0] || v[1])) begin
      if (v[0] && v[1]) w = (k == 1) ? 0 : (m_grant[k] ? 0 : 1);
      else              w = v[1] ? 1 : 0;
      // A continuously requesting port loses at most one round under round-robin.
      if (k == 0 && v[1-w]) begin
        wait_n[k][1-w]++;
        chk("rr_wait_bound", 32'(wait_n[k][1-w] <= 1), 32'd1);
      end
      wait_n[k][w] = 0;
      m_grant[k] = (w == 1);
      m_addr[k]  = (w == 1) ? p1_addr[k]  : p0_addr[k];
      m_wdata[k] = (w == 1) ? p1_wdata[k] : p0_wdata[k];
      m_wstrb[k] = (w == 1) ? p1_wstrb[k] : p0_wstrb[k];
      m_inflight[k] = 1'b1;
      if (n_granted[k] < 8) first_port[k][n_granted[k]] = (w == 1);
      n_granted[k]++;
    end
  endtask

  task automatic compare(input int k);
    chk($sformatf("i%0d mem_valid", k), 32'(mem_valid[k]), 32'(m_inflight[k]));
    chk($sformatf("i%0d mem_addr", k),  32'(mem_addr[k]),  32'(m_addr[k]));
    chk($sformatf("i%0d mem_wdata", k), mem_wdata[k],      m_wdata[k]);
    chk($sformatf("i%0d mem_wstrb", k), 32'(mem_wstrb[k]), 32'(m_wstrb[k]));
    chk($sformatf("i%0d p0_ready", k),  32'(p0_ready[k]),  32'(m_ready[k][0]));
    chk($sformatf("i%0d p1_ready", k),  32'(p1_ready[k]),  32'(m_ready[k][1]));
    chk($sformatf("i%0d p0_rdata", k),  p0_rdata[k],       m_rdata[k][0]);
    chk($sformatf("i%0d p1_rdata", k),  p1_rdata[k],       m_rdata[k][1]);
    chk($sformatf("i%0d grant", k),     32'(grant[k]),     32'(m_grant[k]));
    chk($sformatf("i%0d busy", k),      32'(busy[k]),      32'(m_inflight[k] || m_draining[k]));
  endtask

  // Controller model: answers a request, keeps ready up until it sees valid
  // low plus an optional hold, and can emit stale ready while idle.
  task automatic drive_ctl(input int k);
    if (mem_ready[k]) begin
      if (!mem_valid[k]) begin
        if (ctl_hold[k] == 0) mem_ready[k] = 1'b0;
        else                  ctl_hold[k]--;
      end
    end else if (mem_valid[k]) begin
      if (!rnd_on || $urandom_range(0, 2) == 0) begin
        mem_ready[k] = 1'b1;
        ctl_hold[k]  = (hold_max == 0) ? 0 : int'($urandom_range(0, hold_max));
      end
    end else if (rnd_on && $urandom_range(0, 15) == 0) begin
      mem_ready[k] = 1'b1;
      ctl_hold[k]  = int'($urandom_range(0, 2));
    end
    mem_rdata[k] = $urandom;
  endtask

  function automatic logic next_valid(input logic cur, input logic done, input logic mine);
    if (!cur) return ($urandom_range(0, 2) == 0);
    if (done) return ($urandom_range(0, 1) == 0);
    if (mine) return ($urandom_range(0, 7) != 0);   // occasional abort while issued
    return 1'b1;
  endfunction

  // Requesters: request fields are garbage except in the grant cycle.
  task automatic drive_req(input int k);
    p0_addr[k]  = AW'($urandom);
    p0_wdata[k] = $urandom;
    p0_wstrb[k] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    p1_addr[k]  = AW'($urandom);
    p1_wdata[k] = $urandom;
    p1_wstrb[k] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    if (req_mode == 1) begin
      p0_valid[k] = 1'b1;
      p1_valid[k] = 1'b1;
    end else if (req_mode == 2) begin
      p0_valid[k] = 1'b0;
      p1_valid[k] = 1'b1;
    end else begin
      p0_valid[k] = next_valid(p0_valid[k], p0_ready[k], mem_valid[k] && !grant[k]);
      p1_valid[k] = next_valid(p1_valid[k], p1_ready[k], mem_valid[k] && grant[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      model_step(k);
      compare(k);
    end
    if (auto_on) begin
      for (int k = 0; k < NI; k++) begin
        drive_ctl(k);
        drive_req(k);
      end
    end
  endtask

  task automatic set_p(input int p, input logic v, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    for (int k = 0; k < NI; k++) begin
      if (p == 0) begin
        p0_valid[k] = v; p0_addr[k] = a; p0_wdata[k] = d; p0_wstrb[k] = s;
      end else begin
        p1_valid[k] = v; p1_addr[k] = a; p1_wdata[k] = d; p1_wstrb[k] = s;
      end
    end
  endtask

  task automatic set_mem(input logic r, input logic [31:0] d);
    for (int k = 0; k < NI; k++) begin
      mem_ready[k] = r;
      mem_rdata[k] = d;
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NI; k++) begin
      n_granted[k] = 0;
      pulses[k][0] = 0;
      pulses[k][1] = 0;
      for (int i = 0; i < 8; i++) first_port[k][i] = 1'b0;
    end
  endtask

  initial begin
    int budget;
    resetn = 1'b0;
    auto_on = 1'b0; req_mode = 0; rnd_on = 1'b0; hold_max = 0;
    set_p(0, 1'b0, '0, 32'h0, 4'h0);
    set_p(1, 1'b0, '0, 32'h0, 4'h0);
    set_mem(1'b0, 32'h0);
    for (int k = 0; k < NI; k++) begin
      ctl_hold[k] = 0;
      model_reset(k);
    end
    clear_counts();

    // Reset state
    step(); step();
    chk("reset grant", 32'(grant[0]), 32'd1);
    chk("reset busy", 32'(busy[0]), 32'd0);
    resetn = 1'b1;
    step();

    // Single read from port 0
    set_p(0, 1'b1, 23'h000123, 32'h0, 4'h0);
    step();
    chk("rd mem_valid", 32'(mem_valid[0]), 32'd1);
    chk("rd mem_addr", 32'(mem_addr[0]), 32'h0000_0123);
    set_mem(1'b1, 32'hDEAD_BEEF);
    step();
    chk("rd p0_ready", 32'(p0_ready[0]), 32'd1);
    chk("rd p0_rdata", p0_rdata[0], 32'hDEAD_BEEF);
    chk("rd p1_ready", 32'(p1_ready[0]), 32'd0);
    set_p(0, 1'b0, '0, 32'h0, 4'h0);
    set_mem(1'b0, 32'h0);
    step();
    chk("rd pulse width", 32'(p0_ready[0]), 32'd0);
    chk("rd idle busy", 32'(busy[0]), 32'd0);

    // Write from port 1, request fields trashed after the grant cycle
    set_p(1, 1'b1, 23'h7FFFFF, 32'h0000_A5A5, 4'b0011);
    step();
    for (int i = 0; i < 3; i++) begin
      set_p(1, 1'b1, AW'($urandom), $urandom, 4'($urandom));
      step();
      chk("wr mem_wdata", mem_wdata[0], 32'h0000_A5A5);
      chk("wr mem_wstrb", 32'(mem_wstrb[0]), 32'h3);
      chk("wr grant", 32'(grant[0]), 32'd1);
    end
    set_mem(1'b1, 32'h1234_5678);
    step();
    chk("wr p1_ready", 32'(p1_ready[0]), 32'd1);
    chk("wr p0_ready", 32'(p0_ready[0]), 32'd0);
    chk("wr p0_rdata kept", p0_rdata[0], 32'hDEAD_BEEF);

    // Release gating: ready stays up 5 more cycles while port 1 is pending
    set_p(1, 1'b1, 23'h000456, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rel no grant", 32'(mem_valid[0]), 32'd0);
      chk("rel busy", 32'(busy[0]), 32'd1);
    end
    set_mem(1'b0, 32'h0);
    step();
    chk("rel idle", 32'(mem_valid[0]), 32'd0);
    step();
    chk("rel regrant", 32'(mem_valid[0]), 32'd1);
    chk("rel addr", 32'(mem_addr[0]), 32'h0000_0456);
    set_mem(1'b1, 32'hCAFE_F00D);
    step();
    chk("rel p1_ready", 32'(p1_ready[0]), 32'd1);
    set_p(1, 1'b0, '0, 32'h0, 4'h0);
    set_mem(1'b0, 32'h0);
    step();

    // Asynchronous reset while a request is issued
    set_p(0, 1'b1, 23'h000777, 32'h0, 4'h0);
    step();
    step();
    chk("rst pre mem_valid", 32'(mem_valid[0]), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      model_reset(k);
      compare(k);
    end
    chk("rst async mem_valid", 32'(mem_valid[0]), 32'd0);
    chk("rst async grant", 32'(grant[0]), 32'd1);
    set_mem(1'b1, 32'hBAD0_BAD0);
    step();
    chk("rst no pulse", 32'(p0_ready[0]), 32'd0);
    set_mem(1'b0, 32'h0);
    resetn = 1'b1;
    step();
    chk("rst new grant", 32'(mem_valid[0]), 32'd1);
    chk("rst new addr", 32'(mem_addr[0]), 32'h0000_0777);
    chk("rst still no pulse", 32'(p0_ready[0]), 32'd0);
    set_mem(1'b1, 32'h0BAD_F00D);
    step();
    chk("rst p0_rdata", p0_rdata[0], 32'h0BAD_F00D);
    set_p(0, 1'b0, '0, 32'h0, 4'h0);
    set_mem(1'b0, 32'h0);
    step();

    // Requester abort: valid dropped during ISSUE
    set_p(0, 1'b1, 23'h000ABC, 32'h1111_2222, 4'hF);
    step();
    set_p(0, 1'b0, '0, 32'h0, 4'h0);
    step();
    chk("abort issue held", 32'(mem_valid[0]), 32'd1);
    set_mem(1'b1, 32'h5555_AAAA);
    step();
    chk("abort p0_ready", 32'(p0_ready[0]), 32'd1);
    set_mem(1'b0, 32'h0);
    step();
    chk("abort single pulse", 32'(p0_ready[0]), 32'd0);
    chk("abort idle", 32'(busy[0]), 32'd0);

    // Stale ready in IDLE blocks the grant
    set_mem(1'b1, 32'h0);
    set_p(0, 1'b1, 23'h000321, 32'h0, 4'h0);
    step(); step();
    chk("stale no grant", 32'(mem_valid[0]), 32'd0);
    set_mem(1'b0, 32'h0);
    step();
    chk("stale then grant", 32'(mem_valid[0]), 32'd1);
    set_mem(1'b1, 32'h0);
    step();
    set_p(0, 1'b0, '0, 32'h0, 4'h0);
    set_mem(1'b0, 32'h0);
    step();

    // Both ports hold valid from reset: 4 transactions per instance
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    clear_counts();
    set_p(0, 1'b1, 23'h000010, 32'h0, 4'h0);
    set_p(1, 1'b1, 23'h000020, 32'h0, 4'h0);
    auto_on = 1'b1; req_mode = 1; rnd_on = 1'b0; hold_max = 0;
    budget = 0;
    while ((pulses[0][0] + pulses[0][1] < 4 || pulses[1][0] + pulses[1][1] < 4) && budget < 100) begin
      step();
      budget++;
    end
    chk("rr timeout", 32'(budget < 100), 32'd1);
    chk("rr order", {28'h0, first_port[0][0], first_port[0][1], first_port[0][2], first_port[0][3]}, 32'h5);
    chk("rr p0 pulses", 32'(pulses[0][0]), 32'd2);
    chk("rr p1 pulses", 32'(pulses[0][1]), 32'd2);
    chk("fix order", {28'h0, first_port[1][0], first_port[1][1], first_port[1][2], first_port[1][3]}, 32'h0);
    chk("fix p0 pulses", 32'(pulses[1][0]), 32'd4);
    chk("fix p1 starved", 32'(pulses[1][1]), 32'd0);
    req_mode = 2;
    for (int k = 0; k < NI; k++) p0_valid[k] = 1'b0;
    budget = 0;
    while (pulses[1][1] < 1 && budget < 30) begin
      step();
      budget++;
    end
    chk("fix p1 served after p0 drops", 32'(pulses[1][1]), 32'd1);

    // Randomized traffic with random latency, release hold and stale ready
    req_mode = 0; rnd_on = 1'b1; hold_max = 5;
    for (int i = 0; i < 4000; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qqspi_arbiter.md
Name: qqspi_arbiter

Overview:
Two-port arbiter that shares one qqspi memory controller (PSRAM/SPI-flash, 8Mx32 word space) between two bus requesters, e.g. CPU data port (port 0) and a DMA/video fetch port (port 1). It latches one request, drives the controller's valid/ready handshake including the controller's ready-release phase, and returns read data with a single-cycle ready pulse to the granted requester. Sits between the SoC interconnect and the qqspi instance.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins simultaneous requests
ADDR_W, 23, word address width (8Mx32)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
p0_valid  input  1  port 0 request, held until p0_ready
p0_addr  input  ADDR_W  port 0 word address
p0_wdata  input  32  port 0 write data
p0_wstrb  input  4  port 0 byte strobes; 0 = read
p0_ready  output  1  port 0 completion pulse (1 cycle)
p0_rdata  output  32  port 0 read data, valid while p0_ready
p1_valid, p1_addr, p1_wdata, p1_wstrb, p1_ready, p1_rdata  same as port 0, for port 1
mem_valid  output  1  request to controller
mem_addr  output  ADDR_W  latched address
mem_wdata  output  32  latched write data
mem_wstrb  output  4  latched strobes
mem_ready  input  1  controller completion; stays high until controller sees mem_valid low
mem_rdata  input  32  controller read data, valid while mem_ready
grant  output  1  port currently or last served (0/1)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, resetn=0): state=IDLE, mem_valid=0, mem_addr/wdata/wstrb=0, p0_ready=p1_ready=0, p0_rdata=p1_rdata=0, grant=1 (so port 0 wins first round-robin tie), busy=0. Asserting reset mid-transaction abandons it; no ready pulse is issued afterwards.
- All outputs registered.
- States: IDLE, ISSUE, RELEASE.
- IDLE: if no pN_valid, stay. If exactly one valid, grant it. If both valid: FIXED_PRIO=1 -> port 0; else the port != grant. On grant: latch addr/wdata/wstrb to mem_*, set grant, mem_valid<=1, busy<=1, go ISSUE. A request accepted in IDLE cycle N has mem_valid=1 in cycle N+1.
- ISSUE: hold mem_valid and mem_* stable. When mem_ready=1: capture mem_rdata into p<grant>_rdata, pulse p<grant>_ready for exactly one cycle, mem_valid<=0, go RELEASE. The other port's ready and rdata are unchanged.
- RELEASE: mem_valid=0; wait until mem_ready=0, then go IDLE (busy<=0). No new grant while mem_ready is still high, so the controller's completion of one request is never taken as completion of the next.
- Minimum spacing between grants: ready pulse cycle + at least one RELEASE cycle + IDLE cycle. The granted requester's valid, still high in the cycle after its ready pulse, is treated as a new request only once IDLE is reached.
- Requester rules: pN_addr/wdata/wstrb need only be stable in the IDLE grant cycle, because they are latched. If pN_valid drops while ISSUE is active, the transaction still completes and the ready pulse is still issued.
- Round-robin: grant toggles only when both ports request. A lone requester is served back-to-back indefinitely. With FIXED_PRIO=0, a continuously requesting port waits at most one transaction.
- pN_rdata for writes: whatever mem_rdata holds (don't-care, but still captured).
- mem_ready=1 seen in IDLE (stale): ignored. No grant is made until mem_ready=0. IDLE therefore also waits for mem_ready low.

Test Plan:
- Single read: p0_valid, addr=0x000123, wstrb=0 -> mem_valid next cycle with mem_addr=0x000123; mem_ready with rdata=0xDEADBEEF -> p0_ready one-cycle pulse, p0_rdata=0xDEADBEEF; p1_ready stays 0.
- Write latch: p1 wstrb=4'b0011, wdata=0x0000A5A5, inputs changed to garbage after grant cycle -> mem_wstrb=0011 and mem_wdata=0x0000A5A5 held through ISSUE.
- Round-robin: both ports hold valid for 4 transactions from reset -> grant order 0,1,0,1; each port receives exactly 2 ready pulses. With FIXED_PRIO=1 -> port 0 served 4 times and port 1 starved until p0_valid drops.
- Release gating: controller keeps mem_ready high 5 cycles after mem_valid drops, with p1 pending -> next mem_valid rises only after mem_ready=0.
- Async reset during ISSUE: resetn pulsed low mid-cycle -> all outputs 0 immediately (grant=1), no ready pulse follows; a new p0 request after reset is granted normally.
- Requester abort: p0_valid dropped during ISSUE -> transaction completes, p0_ready still pulses once, arbiter returns to IDLE.
